// File: rtl/pa_fspu_pipe.sv
// pa_fspu_pipe: two-stage FP special-op unit (sign-inject, FP/int moves, classify, optional min/max).
// Define FSPU_MINMAX_EN to build the FMIN/FMAX compare path and NV flag generation.
module pa_fspu_pipe #(
    parameter int FLEN = 32,
    parameter int XLEN = 32,
    parameter int TAGW = 4
) (
    input  logic            cpuclk,
    input  logic            cpurst,
    input  logic            fspu_flush,
    input  logic            fspu_in_vld,
    output logic            fspu_in_rdy,
    input  logic [3:0]      fspu_in_op,
    input  logic            fspu_in_dbl,
    input  logic [FLEN-1:0] fspu_in_srcf0,
    input  logic [FLEN-1:0] fspu_in_srcf1,
    input  logic [XLEN-1:0] fspu_in_srci,
    input  logic [TAGW-1:0] fspu_in_tag,
    output logic            fspu_out_vld,
    input  logic            fspu_out_rdy,
    output logic            fspu_out_dest_i,
    output logic [FLEN-1:0] fspu_out_rst,
    output logic [4:0]      fspu_out_fflags,
    output logic [TAGW-1:0] fspu_out_tag
);
    localparam logic [3:0] OP_FSGNJ  = 4'd0;
    localparam logic [3:0] OP_FSGNJN = 4'd1;
    localparam logic [3:0] OP_FSGNJX = 4'd2;
    localparam logic [3:0] OP_FMV_FX = 4'd3;
    localparam logic [3:0] OP_FMV_XF = 4'd4;
    localparam logic [3:0] OP_FCLASS = 4'd5;
    localparam logic [3:0] OP_FMIN   = 4'd6;
    localparam logic [3:0] OP_FMAX   = 4'd7;

    typedef struct packed {
        logic        sign;
        logic        zero;
        logic        sub;
        logic        norm;
        logic        inf;
        logic        snan;
        logic        qnan;
        logic [62:0] mag;
    } cls_t;

    // Single-precision operands that are not NaN-boxed read as canonical qNaN.
    function automatic logic [63:0] unbox(input logic [63:0] v, input logic dbl);
        if (dbl)
            return v;
        if (FLEN == 64 && v[63:32] != 32'hFFFF_FFFF)
            return 64'h0000_0000_7FC0_0000;
        return {32'h0, v[31:0]};
    endfunction

    function automatic cls_t classify(input logic [63:0] v, input logic dbl);
        cls_t c;
        logic e0, e1, mz, mq;
        if (dbl) begin
            c.sign = v[63];
            e0     = (v[62:52] == 11'h0);
            e1     = &v[62:52];
            mz     = (v[51:0] == 52'h0);
            mq     = v[51];
            c.mag  = v[62:0];
        end else begin
            c.sign = v[31];
            e0     = (v[30:23] == 8'h0);
            e1     = &v[30:23];
            mz     = (v[22:0] == 23'h0);
            mq     = v[22];
            c.mag  = {32'h0, v[30:0]};
        end
        c.zero = e0 & mz;
        c.sub  = e0 & ~mz;
        c.norm = ~e0 & ~e1;
        c.inf  = e1 & mz;
        c.snan = e1 & ~mz & ~mq;
        c.qnan = e1 & mq;
        return c;
    endfunction

    function automatic logic [63:0] box_s(input logic [31:0] v);
        return {32'hFFFF_FFFF, v};
    endfunction

    logic            s1_vld;
    logic [3:0]      s1_op;
    logic            s1_dbl;
    logic [FLEN-1:0] s1_srcf0;
    logic [FLEN-1:0] s1_srcf1;
    logic [XLEN-1:0] s1_srci;
    logic [TAGW-1:0] s1_tag;

    logic            s2_vld;
    logic [FLEN-1:0] s2_rst;
    logic [TAGW-1:0] s2_tag;
    logic            s2_dest_i;

    logic s2_adv;
    logic in_acc;

    assign s2_adv      = !s2_vld || fspu_out_rdy;
    assign fspu_in_rdy = !cpurst && !fspu_flush && (!s1_vld || s2_adv);
    assign in_acc      = fspu_in_vld && fspu_in_rdy;

    always_ff @(posedge cpuclk) begin
        if (cpurst)
            s1_vld <= 1'b0;
        else if (fspu_flush)
            s1_vld <= 1'b0;
        else if (in_acc)
            s1_vld <= 1'b1;
        else if (s2_adv)
            s1_vld <= 1'b0;
    end

    always_ff @(posedge cpuclk) begin
        if (in_acc) begin
            s1_op    <= fspu_in_op;
            s1_dbl   <= (FLEN == 64) && fspu_in_dbl;
            s1_srcf0 <= fspu_in_srcf0;
            s1_srcf1 <= fspu_in_srcf1;
            s1_srci  <= fspu_in_srci;
            s1_tag   <= fspu_in_tag;
        end
    end

    logic [63:0] f0_raw;
    logic [63:0] f0;
    logic [63:0] f1;
    logic [63:0] si;
    cls_t        cls0;
    logic        sgn1;
    logic        sgn_inj;
    logic [9:0]  fclass;
    logic [63:0] res;
    logic        res_nv;
    logic        res_dst;

    assign f0_raw = 64'(s1_srcf0);
    assign si     = 64'(s1_srci);
    assign f0     = unbox(f0_raw, s1_dbl);
    assign f1     = unbox(64'(s1_srcf1), s1_dbl);
    assign cls0   = classify(f0, s1_dbl);
    assign sgn1   = s1_dbl ? f1[63] : f1[31];

    assign fclass = {cls0.qnan, cls0.snan,
                     ~cls0.sign & cls0.inf, ~cls0.sign & cls0.norm,
                     ~cls0.sign & cls0.sub, ~cls0.sign & cls0.zero,
                     cls0.sign & cls0.zero, cls0.sign & cls0.sub,
                     cls0.sign & cls0.norm, cls0.sign & cls0.inf};

    always_comb begin
        case (s1_op[1:0])
            2'd0:    sgn_inj = sgn1;
            2'd1:    sgn_inj = ~sgn1;
            default: sgn_inj = cls0.sign ^ sgn1;
        endcase
    end

`ifdef FSPU_MINMAX_EN
    cls_t        cls1;
    logic        nan0;
    logic        nan1;
    logic        lt;
    logic        pick0;
    logic [63:0] pick;
    logic [63:0] mm_res;
    logic        mm_nv;

    assign cls1 = classify(f1, s1_dbl);

    // Sign first (so -0 < +0), then magnitude, mirrored for negatives.
    always_comb begin
        nan0  = cls0.snan | cls0.qnan;
        nan1  = cls1.snan | cls1.qnan;
        mm_nv = cls0.snan | cls1.snan;
        if (cls0.sign != cls1.sign)
            lt = cls0.sign;
        else if (cls0.sign)
            lt = cls0.mag > cls1.mag;
        else
            lt = cls0.mag < cls1.mag;
        if (nan1)
            pick0 = 1'b1;
        else if (nan0)
            pick0 = 1'b0;
        else
            pick0 = (s1_op == OP_FMIN) ? lt : ~lt;
        pick = pick0 ? f0 : f1;
        if (nan0 && nan1)
            mm_res = s1_dbl ? 64'h7FF8_0000_0000_0000 : box_s(32'h7FC0_0000);
        else
            mm_res = s1_dbl ? pick : box_s(pick[31:0]);
    end
`endif

    always_comb begin
        res     = '0;
        res_nv  = 1'b0;
        res_dst = 1'b0;
        case (s1_op)
            OP_FSGNJ, OP_FSGNJN, OP_FSGNJX: begin
                res = s1_dbl ? {sgn_inj, cls0.mag} : box_s({sgn_inj, cls0.mag[30:0]});
            end
            OP_FMV_FX: begin
                if (!s1_dbl)
                    res = box_s(si[31:0]);
                else if (XLEN == 64)
                    res = si;
            end
            OP_FMV_XF: begin
                res_dst = 1'b1;
                res     = s1_dbl ? f0_raw : {{32{f0_raw[31]}}, f0_raw[31:0]};
            end
            OP_FCLASS: begin
                res_dst = 1'b1;
                res     = {54'h0, fclass};
            end
`ifdef FSPU_MINMAX_EN
            OP_FMIN, OP_FMAX: begin
                res    = mm_res;
                res_nv = mm_nv;
            end
`endif
            default: ;
        endcase
    end

`ifdef FSPU_MINMAX_EN
    logic [4:0] s2_fflags;
    always_ff @(posedge cpuclk) begin
        if (cpurst)
            s2_fflags <= 5'h0;
        else if (s2_adv && s1_vld && !fspu_flush)
            s2_fflags <= {res_nv, 4'h0};
    end
    assign fspu_out_fflags = s2_fflags;
`else
    logic unused_nv;
    assign unused_nv       = res_nv;
    assign fspu_out_fflags = 5'h0;
`endif

    always_ff @(posedge cpuclk) begin
        if (cpurst) begin
            s2_vld    <= 1'b0;
            s2_rst    <= '0;
            s2_tag    <= '0;
            s2_dest_i <= 1'b0;
        end else begin
            if (fspu_flush)
                s2_vld <= 1'b0;
            else if (s2_adv)
                s2_vld <= s1_vld;
            if (s2_adv && s1_vld && !fspu_flush) begin
                s2_rst    <= res[FLEN-1:0];
                s2_tag    <= s1_tag;
                s2_dest_i <= res_dst;
            end
        end
    end

    assign fspu_out_vld    = s2_vld;
    assign fspu_out_rst    = s2_rst;
    assign fspu_out_tag    = s2_tag;
    assign fspu_out_dest_i = s2_dest_i;

endmodule
